// File: rtl/rgb_pkg.sv
// Shared defaults for the single-wire RGB LED link: pulse timing, pixel width
// and the transmitter state encoding.
package rgb_pkg;

  localparam int unsigned BITS_PER_PIXEL    = 32;
  localparam int unsigned T0H_CLKS          = 76;
  localparam int unsigned T0L_CLKS          = 163;
  localparam int unsigned T1H_CLKS          = 153;
  localparam int unsigned T1L_CLKS          = 86;
  localparam int unsigned RESET_CLKS        = 9600;
  localparam int unsigned STREAM_RESET_CLKS = 4800;
  localparam int unsigned COUNTER_MAX       = 9800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_RESET = 2'd3
  } sout_state_t;

endpackage

// File: rtl/rgb_sout_timer.sv
// Loadable down-counter that holds at zero; zero is registered alongside the count.
module rgb_sout_timer #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != '0) begin
      count_next = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_next;
      zero  <= (count_next == '0);
    end
  end

endmodule

// File: rtl/rgb_sout.sv
// Single-wire LED transmitter: one-entry pixel buffer feeding an MSB-first
// pulse serializer, with a low latch period after each last pixel.
module rgb_sout #(
  parameter int unsigned BITS_PER_PIXEL = rgb_pkg::BITS_PER_PIXEL,
  parameter int unsigned T0H_CLKS       = rgb_pkg::T0H_CLKS,
  parameter int unsigned T0L_CLKS       = rgb_pkg::T0L_CLKS,
  parameter int unsigned T1H_CLKS       = rgb_pkg::T1H_CLKS,
  parameter int unsigned T1L_CLKS       = rgb_pkg::T1L_CLKS,
  parameter int unsigned RESET_CLKS     = rgb_pkg::RESET_CLKS,
  parameter int unsigned COUNTER_MAX    = rgb_pkg::COUNTER_MAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_last,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      sig,
  output logic                      busy,
  output logic                      underrun
);

  import rgb_pkg::sout_state_t;
  import rgb_pkg::ST_IDLE;
  import rgb_pkg::ST_HIGH;
  import rgb_pkg::ST_LOW;
  import rgb_pkg::ST_RESET;

  localparam int unsigned TW  = $clog2(COUNTER_MAX + 1);
  localparam int unsigned IW  = $clog2(BITS_PER_PIXEL);
  localparam int unsigned MSB = BITS_PER_PIXEL - 1;

  sout_state_t state;
  sout_state_t state_next;

  logic [BITS_PER_PIXEL-1:0] buf_data;
  logic                      buf_last;
  logic                      buf_full;
  logic [BITS_PER_PIXEL-1:0] shifter;
  logic                      cur_last;
  logic [IW-1:0]             bit_idx;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          load_px;
  logic          shift_bit;
  logic          underrun_c;
  logic          accept;

  // Timer reload values are one less than the phase length.
  function automatic logic [TW-1:0] high_clks(input logic b);
    return b ? TW'(T1H_CLKS - 1) : TW'(T0H_CLKS - 1);
  endfunction

  function automatic logic [TW-1:0] low_clks(input logic b);
    return b ? TW'(T1L_CLKS - 1) : TW'(T0L_CLKS - 1);
  endfunction

  assign pix_ready = !buf_full && !rst;
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state != ST_IDLE) || buf_full;

  rgb_sout_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    load_px    = 1'b0;
    shift_bit  = 1'b0;
    underrun_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_full) begin
          load_px    = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = high_clks(buf_data[MSB]);
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          tmr_val    = low_clks(shifter[MSB]);
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          if (bit_idx != IW'(BITS_PER_PIXEL - 1)) begin
            shift_bit  = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = high_clks(shifter[MSB-1]);
            state_next = ST_HIGH;
          end else if (cur_last) begin
            tmr_load   = 1'b1;
            tmr_val    = TW'(RESET_CLKS - 1);
            state_next = ST_RESET;
          end else if (buf_full) begin
            // Back-to-back pixel: no idle cycle between pixels.
            load_px    = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = high_clks(buf_data[MSB]);
            state_next = ST_HIGH;
          end else begin
            underrun_c = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_RESET: begin
        if (tmr_zero) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // sig follows the next state so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sig      <= 1'b0;
      underrun <= 1'b0;
      buf_data <= '0;
      buf_last <= 1'b0;
      buf_full <= 1'b0;
      shifter  <= '0;
      cur_last <= 1'b0;
      bit_idx  <= '0;
    end else begin
      state    <= state_next;
      sig      <= (state_next == ST_HIGH);
      underrun <= underrun_c;
      if (load_px) begin
        shifter  <= buf_data;
        cur_last <= buf_last;
        bit_idx  <= '0;
      end else if (shift_bit) begin
        shifter <= {shifter[BITS_PER_PIXEL-2:0], 1'b0};
        bit_idx <= bit_idx + IW'(1);
      end
      if (accept) begin
        buf_data <= pix_data;
        buf_last <= pix_last;
        buf_full <= 1'b1;
      end else if (load_px) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_sout.sv
// Bench for rgb_sout with shortened pulse timing; a line monitor measures every
// high/low run and compares it with the bit expectations queued at send time.
module tb_rgb_sout;

  localparam int BPP   = 32;
  localparam int T0H   = 3;
  localparam int T0L   = 8;
  localparam int T1H   = 7;
  localparam int T1L   = 5;
  localparam int RSTC  = 40;
  localparam int CMAX  = 50;
  localparam int GAP   = 50;
  localparam int LIMIT = 2000;

  typedef struct {
    int hi;
    int lo;
    bit chk;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [BPP-1:0] pix_data;
  logic           pix_last;
  logic           pix_valid;
  logic           pix_ready;
  logic           sig;
  logic           busy;
  logic           underrun;

  int   n_chk;
  int   n_pass;
  exp_t q[$];
  exp_t cur;
  bit   have_cur;
  logic prev;
  int   run;
  int   ur_cycles;

  rgb_sout #(
    .BITS_PER_PIXEL (BPP),
    .T0H_CLKS       (T0H),
    .T0L_CLKS       (T0L),
    .T1H_CLKS       (T1H),
    .T1L_CLKS       (T1L),
    .RESET_CLKS     (RSTC),
    .COUNTER_MAX    (CMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .sig       (sig),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Line monitor: each falling edge retires one queued bit.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run      = 0;
      prev     = 1'b0;
      have_cur = 1'b0;
      q.delete();
    end else begin
      if (underrun) ur_cycles++;
      if (sig == prev) begin
        run++;
      end else begin
        if (prev) begin
          if (q.size() == 0) begin
            check("extra_pulse", run, 0);
          end else begin
            e = q.pop_front();
            check("high_len", run, e.hi);
            cur      = e;
            have_cur = 1'b1;
          end
        end else if (have_cur && cur.chk) begin
          check("low_len", run, cur.lo);
        end
        prev = sig;
        run  = 1;
      end
    end
  end

  // Queue the pixel's bits, then offer it; the final bit's low length is
  // TxL + fin_extra when fin_chk is set.
  task automatic send(input logic [BPP-1:0] d, input logic last,
                      input int fin_extra, input bit fin_chk);
    exp_t e;
    int   w;
    for (int i = BPP - 1; i >= 0; i--) begin
      e.hi  = d[i] ? T1H : T0H;
      e.lo  = d[i] ? T1L : T0L;
      e.chk = 1'b1;
      if (i == 0) begin
        e.lo  = e.lo + fin_extra;
        e.chk = fin_chk;
      end
      q.push_back(e);
    end
    pix_data  = d;
    pix_last  = last;
    pix_valid = 1'b1;
    w = 0;
    while (!pix_ready && w < LIMIT) begin
      @(negedge clk); #1;
      w++;
    end
    check("ready_at_offer", int'(pix_ready), 1);
    @(negedge clk); #1;
    pix_valid = 1'b0;
  endtask

  // Wait for the last queued bit to fall.
  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (!(q.size() == 0 && !sig) && w < LIMIT * 4) begin
      @(negedge clk); #1;
      w++;
    end
    check(tag, int'(w < LIMIT * 4), 1);
  endtask

  // From the first low sample of a last pixel's final bit, busy stays high
  // for TxL + RESET cycles with the line low.
  task automatic busy_tail(input string tag, input int want);
    int n;
    int highs;
    n     = 0;
    highs = 0;
    while (busy && n < LIMIT) begin
      if (sig) highs++;
      n++;
      @(negedge clk); #1;
    end
    check(tag, n, want);
    check("tail_sig_low", highs, 0);
  endtask

  initial begin
    int             ur0;
    int             w;
    int             highs;
    logic [BPP-1:0] a;
    logic [BPP-1:0] b;
    logic [BPP-1:0] c;

    n_chk     = 0;
    n_pass    = 0;
    ur_cycles = 0;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sig", int'(sig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_ready_held", int'(pix_ready), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(pix_ready), 1);

    // Single last pixel: 1, thirty 0s, 1, then the latch period.
    ur0 = ur_cycles;
    send(32'h8000_0001, 1'b1, 0, 1'b0);
    check("busy_while_tx", int'(busy), 1);
    wait_drain("drain_single");
    busy_tail("tail_single", T1L + RSTC);
    check("underrun_single", ur_cycles - ur0, 0);

    // Two pixels with valid held: no gap between them.
    ur0 = ur_cycles;
    a = $urandom;
    b = $urandom;
    send(a, 1'b0, 0, 1'b1);
    send(b, 1'b1, 0, 1'b0);
    wait_drain("drain_pair");
    busy_tail("tail_pair", b[0] ? T1L + RSTC : T0L + RSTC);
    check("underrun_pair", ur_cycles - ur0, 0);

    // Underrun: successor arrives GAP cycles after the underrun pulse.
    ur0 = ur_cycles;
    a = $urandom;
    b = $urandom;
    send(a, 1'b0, GAP + 2, 1'b1);
    w = 0;
    while (!underrun && w < LIMIT) begin
      @(negedge clk); #1;
      w++;
    end
    check("underrun_seen", int'(underrun), 1);
    repeat (GAP) begin
      @(negedge clk); #1;
    end
    send(b, 1'b1, 0, 1'b0);
    wait_drain("drain_underrun");
    busy_tail("tail_underrun", b[0] ? T1L + RSTC : T0L + RSTC);
    check("underrun_pulses", ur_cycles - ur0, 1);

    // Reset during the high phase of bit 5 with the buffer holding a pixel.
    ur0 = ur_cycles;
    a = $urandom;
    b = $urandom;
    send(a, 1'b0, 0, 1'b1);
    send(b, 1'b1, 0, 1'b0);
    w = 0;
    while (!(q.size() == 2 * BPP - 5 && sig) && w < LIMIT) begin
      @(negedge clk); #1;
      w++;
    end
    check("reached_bit5", int'(w < LIMIT), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_sig", int'(sig), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(pix_ready), 1);
    highs = 0;
    repeat (300) begin
      @(negedge clk); #1;
      if (sig) highs++;
    end
    check("abort_no_pulses", highs, 0);
    check("abort_underrun", ur_cycles - ur0, 0);

    // Pixel offered during the latch period starts one cycle after it ends.
    a = $urandom;
    b = $urandom;
    send(a, 1'b1, RSTC + 1, 1'b1);
    wait_drain("drain_latch_a");
    repeat (15) begin
      @(negedge clk); #1;
    end
    check("busy_in_latch", int'(busy), 1);
    send(b, 1'b1, 0, 1'b0);
    wait_drain("drain_latch_b");
    busy_tail("tail_latch", b[0] ? T1L + RSTC : T0L + RSTC);

    // Random three-pixel frame.
    ur0 = ur_cycles;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    send(a, 1'b0, 0, 1'b1);
    send(b, 1'b0, 0, 1'b1);
    send(c, 1'b1, 0, 1'b0);
    wait_drain("drain_frame");
    busy_tail("tail_frame", c[0] ? T1L + RSTC : T0L + RSTC);
    check("underrun_frame", ur_cycles - ur0, 0);
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
